sram_stage_sequencer: RTL and testbench

- Parametrised successor to the hard-coded top-level flow controller and SRAM bus mux.
- Runs N processing stages (milestone units) in fixed index order using a level Start / Done handshake.
- Routes the single SRAM controller port to whichever stage is active, and to a default owner (VGA reader) otherwise.
- Supports a per-run stage-skip mask, abort, and status outputs. Sits between the UART-receive phase and the SRAM controller.

---
 rtl/sram_stage_sequencer_if.sv | 41 ++++
 rtl/sram_stage_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stage_sequencer_if.sv
// Bundle between the stage sequencer, its processing stages, the default
// SRAM owner and the SRAM controller. master = sequencer side.
interface sram_stage_sequencer_if #(
   parameter int N_STAGES = 3,
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16
);
   logic                         Go;
   logic                         Abort;
   logic [N_STAGES-1:0]          Stage_mask;
   logic [N_STAGES-1:0]          Stage_start;
   logic [N_STAGES-1:0]          Stage_done;
   logic [N_STAGES*ADDR_W-1:0]   Stage_SRAM_address;
   logic [N_STAGES*DATA_W-1:0]   Stage_SRAM_write_data;
   logic [N_STAGES-1:0]          Stage_SRAM_we_n;
   logic [ADDR_W-1:0]            Default_SRAM_address;
   logic [ADDR_W-1:0]            SRAM_address;
   logic [DATA_W-1:0]            SRAM_write_data;
   logic                         SRAM_we_n;
   logic                         Busy;
   logic [2:0]                   Active_stage;
   logic                         Seq_done;
   logic                         Seq_aborted;
   logic                         Timeout_flag;

   modport master (
      input  Go, Abort, Stage_mask, Stage_done,
      input  Stage_SRAM_address, Stage_SRAM_write_data, Stage_SRAM_we_n,
      input  Default_SRAM_address,
      output Stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
      output Busy, Active_stage, Seq_done, Seq_aborted, Timeout_flag
   );

   modport slave (
      output Go, Abort, Stage_mask, Stage_done,
      output Stage_SRAM_address, Stage_SRAM_write_data, Stage_SRAM_we_n,
      output Default_SRAM_address,
      input  Stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
      input  Busy, Active_stage, Seq_done, Seq_aborted, Timeout_flag
   );
endinterface

// File: rtl/sram_stage_sequencer.sv
// Runs N_STAGES milestone stages in index order via level Start/Done and muxes
// the single SRAM port to the running stage. Optional watchdog: STAGE_TIMEOUT_EN.
module sram_stage_sequencer #(
   parameter int          N_STAGES       = 3,
   parameter int          ADDR_W         = 18,
   parameter int          DATA_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input logic                     CLOCK_50,
   input logic                     Resetn,
   sram_stage_sequencer_if.master  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]          state;
   logic [N_STAGES-1:0] mask_r;
   logic [3:0]          scan_idx;
   logic [2:0]          active_stage;
   logic [N_STAGES-1:0] stage_start;
   logic                busy;
   logic                seq_done;
   logic                seq_aborted;
   logic                first_run;

   logic                sel_found;
   logic [2:0]          sel_idx;
   logic                done_act;
   logic                done_now;
   logic                timeout_hit;
   logic                abort_now;

   logic [ADDR_W-1:0]   sram_address;
   logic [DATA_W-1:0]   sram_write_data;
   logic                sram_we_n;

   // Lowest enabled stage at or above scan_idx; scan_idx may equal N_STAGES
   // once the last stage has finished, which simply yields no match.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         if (mask_r[i] && (4'(i) >= scan_idx)) begin
            sel_found = 1'b1;
            sel_idx   = 3'(i);
         end
      end
   end

   // Bus owner is decided only by registered state, so GAP/IDLE always
   // present the default reader with writes disabled.
   always_comb begin
      done_act        = 1'b0;
      sram_address    = bus.Default_SRAM_address;
      sram_write_data = '0;
      sram_we_n       = 1'b1;
      for (int i = 0; i < N_STAGES; i++) begin
         if (active_stage == 3'(i)) begin
            done_act = bus.Stage_done[i];
            if (state == S_RUN) begin
               sram_address    = bus.Stage_SRAM_address[i*ADDR_W +: ADDR_W];
               sram_write_data = bus.Stage_SRAM_write_data[i*DATA_W +: DATA_W];
               sram_we_n       = bus.Stage_SRAM_we_n[i];
            end
         end
      end
   end

   assign done_now  = (state == S_RUN) && !first_run && done_act;
   assign abort_now = bus.Abort || timeout_hit;

`ifdef STAGE_TIMEOUT_EN
   logic [31:0] run_cnt;
   logic        timeout_flag_r;

   assign timeout_hit = (state == S_RUN) && !done_now &&
                        (run_cnt == 32'(TIMEOUT_CYCLES - 32'd1));

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         run_cnt        <= '0;
         timeout_flag_r <= 1'b0;
      end else begin
         if (state == S_IDLE && bus.Go && !bus.Abort)
            timeout_flag_r <= 1'b0;
         else if (timeout_hit)
            timeout_flag_r <= 1'b1;

         if (state == S_SELECT)
            run_cnt <= '0;
         else if (state == S_RUN)
            run_cnt <= run_cnt + 32'd1;
      end
   end

   assign bus.Timeout_flag = timeout_flag_r;
`else
   assign timeout_hit      = 1'b0;
   assign bus.Timeout_flag = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state        <= S_IDLE;
         mask_r       <= '0;
         scan_idx     <= '0;
         active_stage <= '0;
         stage_start  <= '0;
         busy         <= 1'b0;
         seq_done     <= 1'b0;
         seq_aborted  <= 1'b0;
         first_run    <= 1'b0;
      end else begin
         seq_done    <= 1'b0;
         seq_aborted <= 1'b0;
         if (state == S_IDLE) begin
            if (bus.Go && !bus.Abort) begin
               mask_r   <= bus.Stage_mask;
               scan_idx <= '0;
               busy     <= 1'b1;
               state    <= S_SELECT;
            end
         end else if (abort_now) begin
            // Abort outranks a same-cycle Stage_done or completion.
            stage_start  <= '0;
            seq_aborted  <= 1'b1;
            busy         <= 1'b0;
            active_stage <= '0;
            first_run    <= 1'b0;
            state        <= S_IDLE;
         end else begin
            case (state)
               S_SELECT: begin
                  if (sel_found) begin
                     active_stage <= sel_idx;
                     stage_start  <= N_STAGES'(1) << sel_idx;
                     first_run    <= 1'b1;
                     state        <= S_RUN;
                  end else begin
                     state <= S_FINISH;
                  end
               end
               S_RUN: begin
                  first_run <= 1'b0;
                  if (done_now) begin
                     stage_start <= '0;
                     scan_idx    <= 4'(active_stage) + 4'd1;
                     state       <= S_GAP;
                  end
               end
               S_GAP: begin
                  state <= S_SELECT;
               end
               S_FINISH: begin
                  seq_done     <= 1'b1;
                  busy         <= 1'b0;
                  active_stage <= '0;
                  state        <= S_IDLE;
               end
               default: begin
                  stage_start <= '0;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.Stage_start     = stage_start;
   assign bus.Busy            = busy;
   assign bus.Active_stage    = active_stage;
   assign bus.Seq_done        = seq_done;
   assign bus.Seq_aborted     = seq_aborted;
   assign bus.SRAM_address    = sram_address;
   assign bus.SRAM_write_data = sram_write_data;
   assign bus.SRAM_we_n       = sram_we_n;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Scoreboard bench for sram_stage_sequencer: directed runs push expected
// events, a negedge monitor pops and compares what the DUT presents.
module tb_sram_stage_sequencer;

   localparam int N  = 3;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam logic [AW-1:0] DEF_ADDR = 18'd146944;

   localparam int EV_START = 0;
   localparam int EV_BUS   = 1;
   localparam int EV_END   = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_ABORT = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   sram_stage_sequencer_if #(.N_STAGES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_stage_sequencer #(
      .N_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(20)
   ) dut (
      .CLOCK_50(clk),
      .Resetn  (resetn),
      .bus     (bus.master)
   );

   typedef struct {
      int          kind;
      logic [63:0] val;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          go_cyc = 0;
   int          delay[N];
   int          cnt[N];
   logic [N-1:0] model_done;
   logic [N-1:0] done_or = '0;
   logic        tog1   = 1'b0;
   logic        tog_ph = 1'b0;
   bit          mon_en = 1'b0;
   logic [N-1:0] prev_start = '0;
   int          run_len = 0;

   logic [AW-1:0] stage_addr[N];
   logic [DW-1:0] stage_data[N];

   // Stage models: stage i writes while started and raises done once Start
   // has been high for delay[i]+1 negedges (delay 5 -> done in 6th Start cycle).
   assign bus.Stage_SRAM_address    = {18'h3456, 18'h2345, 18'h1234};
   assign bus.Stage_SRAM_write_data = {16'hA002, 16'hA001, 16'hA000};
   assign bus.Stage_SRAM_we_n       = ~bus.Stage_start;
   assign bus.Default_SRAM_address  = DEF_ADDR;
   assign bus.Stage_done            = model_done | done_or | {1'b0, tog1 & tog_ph, 1'b0};

   always_comb begin
      model_done = '0;
      for (int i = 0; i < N; i++)
         model_done[i] = bus.Stage_start[i] && (cnt[i] > delay[i]);
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
         cnt[i] = bus.Stage_start[i] ? cnt[i] + 1 : 0;
      tog_ph = ~tog_ph;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic string kname(input int k);
      case (k)
         EV_START: return "start";
         EV_BUS:   return "bus";
         EV_END:   return "end";
         EV_DONE:  return "seq_done";
         EV_ABORT: return "seq_aborted";
         default:  return "unknown";
      endcase
   endfunction

   function automatic logic [63:0] bus_val(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic w);
      return {29'd0, a, d, w};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic observe(input int k, input logic [63:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected %s event at cycle %0d: got 0x%0h, expected none",
                  kname(k), cyc, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val !== v) begin
            errors++;
            $display("FAIL %s event at cycle %0d: got 0x%0h, expected %s 0x%0h",
                     kname(k), cyc, v, kname(e.kind), e.val);
         end
      end
   endtask

   task automatic push(input int k, input logic [63:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   // START encodes Active_stage*256 + Stage_start; END encodes
   // duration*4 + we_n*2 + (address==default), so a clean GAP/IDLE gives +3.
   task automatic exp_stage(input int s, input int dur);
      push(EV_START, 64'(s * 256 + (1 << s)));
      push(EV_BUS,   bus_val(stage_addr[s], stage_data[s], 1'b0));
      push(EV_END,   64'(dur * 4 + 3));
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (bus.Stage_start != 0 && prev_start == 0) begin
            run_len = 1;
            observe(EV_START, 64'(bus.Active_stage) * 256 + 64'(bus.Stage_start));
            observe(EV_BUS, bus_val(bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n));
         end else if (bus.Stage_start != 0) begin
            run_len++;
         end
         if (bus.Stage_start == 0 && prev_start != 0)
            observe(EV_END, 64'(run_len * 4) + 64'(bus.SRAM_we_n) * 2 +
                            64'(bus.SRAM_address == DEF_ADDR));
         if (bus.Seq_done)
            observe(EV_DONE, 64'(cyc - go_cyc));
         if (bus.Seq_aborted)
            observe(EV_ABORT, {58'd0, bus.Stage_start, bus.Busy, bus.SRAM_we_n,
                               bus.SRAM_address == DEF_ADDR});
      end
      prev_start = bus.Stage_start;
   end

   task automatic go(input logic [N-1:0] m);
      @(negedge clk);
      bus.Stage_mask = m;
      bus.Go         = 1'b1;
      go_cyc         = cyc;
      @(negedge clk);
      bus.Go = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         if (!bus.Busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 64'(ok), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      stage_addr = '{18'h1234, 18'h2345, 18'h3456};
      stage_data = '{16'hA000, 16'hA001, 16'hA002};
      delay      = '{5, 5, 5};
      bus.Go         = 1'b0;
      bus.Abort      = 1'b0;
      bus.Stage_mask = '0;

      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_stage_start",  64'(bus.Stage_start),     64'd0);
      chk("rst_busy",         64'(bus.Busy),            64'd0);
      chk("rst_active_stage", 64'(bus.Active_stage),    64'd0);
      chk("rst_seq_done",     64'(bus.Seq_done),        64'd0);
      chk("rst_seq_aborted",  64'(bus.Seq_aborted),     64'd0);
      chk("rst_timeout_flag", 64'(bus.Timeout_flag),    64'd0);
      chk("idle_address",     64'(bus.SRAM_address),    64'd146944);
      chk("idle_we_n",        64'(bus.SRAM_we_n),       64'd1);
      chk("idle_write_data",  64'(bus.SRAM_write_data), 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // Full mask, 6-cycle stages, plus a Go pulse mid-run that must be ignored.
      exp_stage(0, 6);
      exp_stage(1, 6);
      exp_stage(2, 6);
      push(EV_DONE, 64'd27);
      go(3'b111);
      repeat (12) @(negedge clk);
      bus.Stage_mask = 3'b010;
      bus.Go         = 1'b1;
      @(negedge clk);
      bus.Go = 1'b0;
      wait_idle("t1_idle", 60);
      @(negedge clk);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Mask 101 with stage 1 done toggling: stage 1 must never start.
      tog1 = 1'b1;
      exp_stage(0, 6);
      exp_stage(2, 6);
      push(EV_DONE, 64'd19);
      go(3'b101);
      wait_idle("t2_idle", 60);
      @(negedge clk);
      tog1 = 1'b0;
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Empty mask: Seq_done 3 cycles after Go, bus stays with default owner.
      push(EV_DONE, 64'd3);
      go(3'b000);
      chk("t3_c1_start", 64'(bus.Stage_start), 64'd0);
      chk("t3_c1_we_n",  64'(bus.SRAM_we_n),   64'd1);
      chk("t3_c1_busy",  64'(bus.Busy),        64'd1);
      @(negedge clk);
      chk("t3_c2_we_n",  64'(bus.SRAM_we_n),   64'd1);
      chk("t3_c2_busy",  64'(bus.Busy),        64'd1);
      @(negedge clk);
      chk("t3_c3_busy",  64'(bus.Busy),        64'd0);
      chk("t3_c3_we_n",  64'(bus.SRAM_we_n),   64'd1);
      @(negedge clk);
      chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Stale done held high: first RUN cycle ignores it, so Start lasts 2 cycles.
      done_or = 3'b001;
      exp_stage(0, 2);
      push(EV_DONE, 64'd7);
      go(3'b001);
      wait_idle("t4_idle", 20);
      @(negedge clk);
      done_or = '0;
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // Abort in 3rd RUN cycle of stage 1 together with its done.
      delay = '{5, 1000, 5};
      exp_stage(0, 6);
      push(EV_START, 64'(256 + 2));
      push(EV_BUS,   bus_val(18'h2345, 16'hA001, 1'b0));
      push(EV_END,   64'(3 * 4 + 3));
      push(EV_ABORT, 64'd3);
      go(3'b111);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.Stage_start[1]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_stage1_started", 64'(ok), 64'd1);
      repeat (2) @(negedge clk);
      bus.Abort = 1'b1;
      done_or   = 3'b010;
      @(negedge clk);
      bus.Abort = 1'b0;
      done_or   = '0;
      chk("t5_start_cleared", 64'(bus.Stage_start),  64'd0);
      chk("t5_busy",          64'(bus.Busy),         64'd0);
      chk("t5_active_stage",  64'(bus.Active_stage), 64'd0);
      chk("t5_no_seq_done",   64'(bus.Seq_done),     64'd0);
      @(negedge clk);
      chk("t5_aborted_pulse_ended", 64'(bus.Seq_aborted), 64'd0);
      chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
      delay = '{5, 5, 5};

      // Go and Abort together in IDLE: nothing starts, no pulses.
      @(negedge clk);
      bus.Stage_mask = 3'b111;
      bus.Go         = 1'b1;
      bus.Abort      = 1'b1;
      @(negedge clk);
      bus.Go    = 1'b0;
      bus.Abort = 1'b0;
      chk("t6_busy",  64'(bus.Busy),        64'd0);
      chk("t6_start", 64'(bus.Stage_start), 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_busy_later", 64'(bus.Busy), 64'd0);

`ifdef STAGE_TIMEOUT_EN
      // Stage never done: watchdog aborts after 20 RUN cycles.
      delay = '{1000, 1000, 1000};
      exp_stage(0, 20);
      push(EV_ABORT, 64'd3);
      go(3'b001);
      wait_idle("t7_idle", 60);
      @(negedge clk);
      chk("t7_timeout_flag", 64'(bus.Timeout_flag), 64'd1);
      chk("t7_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk("t7_timeout_flag_sticky", 64'(bus.Timeout_flag), 64'd1);
      push(EV_DONE, 64'd3);
      go(3'b000);
      chk("t7_timeout_flag_cleared", 64'(bus.Timeout_flag), 64'd0);
      repeat (3) @(negedge clk);
      chk("t7_queue_empty2", 64'(exp_q.size()), 64'd0);
      delay = '{5, 5, 5};
`else
      chk("t7_timeout_flag_tied", 64'(bus.Timeout_flag), 64'd0);
`endif

      // Asynchronous reset in the middle of stage 0.
      push(EV_START, 64'd1);
      push(EV_BUS,   bus_val(18'h1234, 16'hA000, 1'b0));
      go(3'b111);
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("t8_start_async", 64'(bus.Stage_start),  64'd0);
      chk("t8_busy_async",  64'(bus.Busy),         64'd0);
      chk("t8_active",      64'(bus.Active_stage), 64'd0);
      chk("t8_we_n",        64'(bus.SRAM_we_n),    64'd1);
      chk("t8_address",     64'(bus.SRAM_address), 64'd146944);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      chk("t8_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
